// File: rtl/alu_issue.sv
// ALU issue register: decodes an RV32I word and bypasses its register operands.
// Presents them as one registered op with valid/ready flow control and saturating counters.
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1data,
  input  logic [31:0]      rs2data,
  input  logic             fwd_valid,
  input  logic [4:0]       fwd_rd,
  input  logic [31:0]      fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      srca,
  output logic [31:0]      srcb,
  output logic [2:0]       alucontrol,
  output logic [4:0]       rd,
  output logic             is_branch,
  output logic             branch_ne,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     ctl;
    logic [4:0]  rd;
    logic        br;
    logic        ne;
    logic        ill;
  } op_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] ra;
  logic [4:0] rb;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign ra  = instr[19:15];
  assign rb  = instr[24:20];

  logic [31:0] rs1v;
  logic [31:0] rs2v;
  logic        fwd_on;

  // x0 wins over any bypass, so a stray fwd_rd of 0 never leaks through
  assign fwd_on = fwd_valid && (fwd_rd != 5'd0);

  always_comb begin
    rs1v = rs1data;
    rs2v = rs2data;
    if (fwd_on && fwd_rd == ra) rs1v = fwd_data;
    if (fwd_on && fwd_rd == rb) rs2v = fwd_data;
    if (ra == 5'd0) rs1v = '0;
    if (rb == 5'd0) rs2v = '0;
  end

  logic [31:0] imm_i;
  logic [31:0] imm_s;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};

  logic op_r;
  logic op_i;
  logic op_ld;
  logic op_st;
  logic op_br;
  logic op_lui;

  assign op_r   = (opc == 7'b0110011);
  assign op_i   = (opc == 7'b0010011);
  assign op_ld  = (opc == 7'b0000011);
  assign op_st  = (opc == 7'b0100011);
  assign op_br  = (opc == 7'b1100011);
  assign op_lui = (opc == 7'b0110111);

  alu_op_e arith_ctl;
  logic    arith_ill;

  // f3 map shared by R- and I-type; shift legality differs
  always_comb begin
    arith_ctl = ALU_ADD;
    arith_ill = 1'b0;
    unique case (f3)
      3'b000: arith_ctl = (op_r && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b111: arith_ctl = ALU_AND;
      3'b110: arith_ctl = ALU_OR;
      3'b100: arith_ctl = ALU_XOR;
      3'b010: arith_ctl = ALU_SLT;
      3'b011: arith_ill = 1'b1;
      3'b001: begin
        arith_ctl = ALU_SLL;
        arith_ill = op_i && (f7 != 7'd0);
      end
      3'b101: begin
        arith_ctl = ALU_SRL;
        arith_ill = op_r ? instr[30] : (f7 != 7'd0);
      end
      default: arith_ill = 1'b1;
    endcase
  end

  op_t dec;

  always_comb begin
    dec     = '0;
    dec.ctl = ALU_ADD;
    dec.a   = rs1v;
    dec.b   = rs2v;
    dec.rd  = instr[11:7];
    unique case (1'b1)
      op_r: begin
        dec.ctl = arith_ctl;
        dec.ill = arith_ill;
      end
      op_i: begin
        dec.ctl = arith_ctl;
        dec.ill = arith_ill;
        dec.b   = imm_i;
      end
      op_ld: begin
        dec.b   = imm_i;
        dec.ill = (f3 != 3'b010);
      end
      op_st: begin
        dec.b   = imm_s;
        dec.rd  = 5'd0;
        dec.ill = (f3 != 3'b010);
      end
      op_br: begin
        dec.ctl = ALU_SUB;
        dec.br  = 1'b1;
        dec.ne  = f3[0];
        dec.rd  = 5'd0;
        dec.ill = (f3[2:1] != 2'b00);
      end
      op_lui: begin
        dec.a = '0;
        dec.b = {instr[31:12], 12'b0};
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  op_t             pay_q, pay_d;
  logic            vld_q, vld_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] xcnt_q, xcnt_d;
  logic            accept;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    pay_d  = pay_q;
    vld_d  = vld_q;
    icnt_d = icnt_q;
    xcnt_d = xcnt_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (accept) begin
      pay_d = dec;
      vld_d = 1'b1;
      if (!dec.ill && icnt_q != '1) icnt_d = icnt_q + CNT_W'(1);
      if (dec.ill && xcnt_q != '1)  xcnt_d = xcnt_q + CNT_W'(1);
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pay_q  <= '0;
      vld_q  <= 1'b0;
      icnt_q <= '0;
      xcnt_q <= '0;
    end else begin
      pay_q  <= pay_d;
      vld_q  <= vld_d;
      icnt_q <= icnt_d;
      xcnt_q <= xcnt_d;
    end
  end

  assign out_valid   = vld_q;
  assign srca        = pay_q.a;
  assign srcb        = pay_q.b;
  assign alucontrol  = pay_q.ctl;
  assign rd          = pay_q.rd;
  assign is_branch   = pay_q.br;
  assign branch_ne   = pay_q.ne;
  assign illegal     = pay_q.ill;
  assign issue_cnt   = icnt_q;
  assign illegal_cnt = xcnt_q;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Register stage that drives the ALU's operand/control interface: srca, srcb, 3-bit alucontrol.
- Accepts one decoded-from-raw RV32I instruction plus register-file read data per handshake.
- Decodes the ALU operation, selects and forwards operands, and presents them in a registered output with valid/ready flow control.
- Sits between register read and the ALU in the execute stage. Also carries branch and illegal-instruction qualifiers and saturating issue counters.

Parameters:
- CNT_W, 16, width of the issued-op and illegal-op saturating counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of the held and incoming op.
- in_valid  in  1  instruction and operands present.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  raw instruction word.
- rs1data  in  32  register-file read for instr[19:15].
- rs2data  in  32  register-file read for instr[24:20].
- fwd_valid  in  1  bypass data valid.
- fwd_rd  in  5  bypass destination register.
- fwd_data  in  32  bypass value.
- out_valid  out  1  registered op valid.
- out_ready  in  1  ALU side consumes op.
- srca  out  32  ALU operand a.
- srcb  out  32  ALU operand b.
- alucontrol  out  3  ALU opcode.
- rd  out  5  destination register; 0 for branch/store.
- is_branch  out  1  branch op; downstream tests zero.
- branch_ne  out  1  1 = bne, 0 = beq.
- illegal  out  1  unsupported encoding.
- issue_cnt  out  CNT_W  accepted legal ops.
- illegal_cnt  out  CNT_W  accepted illegal ops.

Behaviour:

ALU encoding:
- 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.

Decode (f3 = instr[14:12], f7b5 = instr[30]):
- R-type 0110011:
  - f3 000: f7b5 ? sub : add.
  - 111 and, 110 or, 100 xor, 010 slt, 001 sll.
  - 101 with f7b5 = 0: srl.
  - sltu, sra: illegal.
  - srcb = rs2.
- I-type 0010011:
  - Same f3 map; f3 000 is always add.
  - slli/srli require instr[31:25] = 0; srai and sltiu are illegal.
  - srcb = sign-extended instr[31:20].
- lw 0000011 (f3 010): add; srcb = I-immediate.
- sw 0100011 (f3 010): add; srcb = S-immediate {instr[31:25], instr[11:7]} sign-extended; rd = 0.
- beq/bne 1100011 (f3 000/001): sub; srcb = rs2; is_branch = 1; branch_ne = f3[0]; rd = 0.
- lui 0110111: add; srca = 0; srcb = {instr[31:12], 12'b0}.
- Anything else: illegal = 1, alucontrol = 000, srca = srcb = 0, rd = 0, is_branch = 0.

Operand selection (combinational, captured at accept):
- Register index 0 reads as 0 regardless of rsXdata.
- If fwd_valid and fwd_rd != 0 and fwd_rd equals the index, use fwd_data instead of rsXdata.

Handshake:
- in_ready = !out_valid | out_ready (combinational).
- Accept = in_valid & in_ready & !flush. On accept, all outputs load next edge and out_valid = 1.
- If out_ready & out_valid & !accept: out_valid = 0.
- Held payload is stable while out_valid & !out_ready.
- Zero bubbles under continuous valid/ready: 1 op per cycle, latency 1 cycle.

Flush:
- flush = 1 forces out_valid = 0 next edge and blocks accept in that cycle.
- Flush takes priority over accept and hold.

Counters:
- On accept, issue_cnt increments if not illegal; otherwise illegal_cnt increments.
- Both saturate at all-ones. Flushed ops are never counted.

Reset:
- All outputs and counters are 0 immediately, independent of clk.
- Reset mid-hold discards the held op. in_ready = 1 after reset.

Test Plan:
1. Reset, then add x3,x1,x2 with rs1data = 5, rs2data = 7, out_ready = 1 -> next cycle out_valid = 1, srca = 5, srcb = 7, alucontrol = 000, rd = 3, issue_cnt = 1.
2. addi x1,x0,-1 (instr 0xFFF00093) with rs1data = 0x1234 -> srca = 0, srcb = 0xFFFFFFFF, alucontrol = 000.
3. bne x1,x2 with fwd_valid = 1, fwd_rd = 1, fwd_data = 9, rs1data = 4 -> srca = 9, alucontrol = 001, is_branch = 1, branch_ne = 1, rd = 0.
4. Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, payload unchanged; out_ready = 1 -> next op loads same edge, no bubble; issue_cnt increments exactly once per accept.
5. sra encoding 0x4020D1B3 -> illegal = 1, alucontrol = 000, illegal_cnt = 1, issue_cnt unchanged.
6. flush asserted with in_valid = 1 while out_valid = 1 -> next cycle out_valid = 0 and counters unchanged. Then assert async reset mid-cycle -> outputs 0 before next clk edge.
